// File: rtl/mutative_policy_ctrl.sv
// rtl/mutative_policy_ctrl.sv - miss-classifying cache associativity policy controller
module mutative_policy_ctrl #(
  parameter int NUM_MODES   = 4,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 64,
  parameter int UP_THRESH   = 32,
  parameter int DOWN_THRESH = 16,
  parameter int CONFLICT_WT = 2,
  parameter int CAPACITY_WT = 1,
  localparam int MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cache_ready,
  input  logic              real_cache_valid,
  input  logic              real_cache_hit,
  input  logic              real_cache_full,
  input  logic              full_assoc_hit,
  input  logic              full_assoc_full,
  input  logic              force_valid,
  input  logic [MODE_W-1:0] force_mode,
  output logic [MODE_W-1:0] mode,
  output logic              switch_req,
  output logic [MODE_W-1:0] target_mode,
  input  logic              switch_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  req_count,
  output logic [CNT_W-1:0]  score
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_WAIT, S_EVAL, S_SWITCH
  } state_t;

  // Score arithmetic is done two bits wider so the saturation test sees the true sum.
  localparam int EW = CNT_W + 2;
  localparam logic [MODE_W-1:0]    MAX_MODE = MODE_W'(NUM_MODES - 1);
  localparam logic [CNT_W-1:0]     WIN_CNT  = CNT_W'(WINDOW);
  localparam logic signed [EW-1:0] UP_LIM   = EW'(UP_THRESH);
  localparam logic signed [EW-1:0] DN_LIM   = EW'(-DOWN_THRESH);
  localparam logic signed [EW-1:0] SC_MAX   = {3'b000, {(CNT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SC_MIN   = {3'b111, {(CNT_W-1){1'b0}}};

  state_t                  state, state_nx;
  logic [MODE_W-1:0]       mode_q, target_q;
  logic [CNT_W-1:0]        score_q;
  logic [CNT_W-1:0]        hit_q, req_q;
  logic                    pending_q;

  logic                    is_hit, is_conflict, is_capacity;
  logic [CNT_W-1:0]        req_inc, hit_inc;
  logic                    window_done;
  logic signed [EW-1:0]    score_ext, score_sum;
  logic [CNT_W-1:0]        score_nx;
  logic                    eval_up, eval_down;
  logic [MODE_W-1:0]       force_clamped;

  // Classify the outcome, form saturated counter updates and the window decision.
  always_comb begin
    is_hit      = real_cache_valid & real_cache_hit;
    is_conflict = real_cache_valid & ~real_cache_hit & (full_assoc_hit | ~real_cache_full);
    is_capacity = real_cache_valid & ~real_cache_hit & ~full_assoc_hit
                  & real_cache_full & full_assoc_full;
    req_inc     = (req_q == '1) ? req_q : req_q + 1'b1;
    hit_inc     = (hit_q == '1) ? hit_q : hit_q + 1'b1;
    window_done = (req_inc >= WIN_CNT);
    score_ext   = {{2{score_q[CNT_W-1]}}, score_q};
    score_sum   = score_ext;
    if (is_conflict) begin
      score_sum = score_ext + EW'(CONFLICT_WT);
    end else if (is_capacity) begin
      score_sum = score_ext - EW'(CAPACITY_WT);
    end
    if (score_sum > SC_MAX) begin
      score_nx = SC_MAX[CNT_W-1:0];
    end else if (score_sum < SC_MIN) begin
      score_nx = SC_MIN[CNT_W-1:0];
    end else begin
      score_nx = score_sum[CNT_W-1:0];
    end
    eval_up       = (score_ext >= UP_LIM) && (mode_q < MAX_MODE);
    eval_down     = (score_ext <= DN_LIM) && (mode_q != '0);
    force_clamped = (int'(force_mode) > NUM_MODES - 1) ? MAX_MODE : force_mode;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; the final request of a window must complete before EVAL.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (force_valid) begin
          state_nx = S_SWITCH;
        end else if (cpu_req) begin
          state_nx = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        if (window_done) begin
          state_nx = cache_ready ? S_EVAL : S_WAIT;
        end else begin
          state_nx = cache_ready ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cache_ready) begin
          state_nx = pending_q ? S_EVAL : S_IDLE;
        end
      end
      S_EVAL: begin
        state_nx = (eval_up || eval_down) ? S_SWITCH : S_IDLE;
      end
      S_SWITCH: begin
        if (switch_ack) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registered datapath.
  always_comb begin
    switch_req  = (state == S_SWITCH);
    mode        = mode_q;
    target_mode = target_q;
    hit_count   = hit_q;
    req_count   = req_q;
    score       = score_q;
  end

  // Datapath: counters, mode, switch target and the end-of-window pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= '0;
      target_q  <= '0;
      score_q   <= '0;
      hit_q     <= '0;
      req_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (force_valid) begin
            target_q <= force_clamped;
          end
        end
        S_CLASSIFY: begin
          req_q   <= req_inc;
          score_q <= score_nx;
          if (is_hit) begin
            hit_q <= hit_inc;
          end
          if (window_done && !cache_ready) begin
            pending_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cache_ready) begin
            pending_q <= 1'b0;
          end
        end
        S_EVAL: begin
          if (eval_up) begin
            target_q <= mode_q + 1'b1;
          end else if (eval_down) begin
            target_q <= mode_q - 1'b1;
          end else begin
            score_q <= '0;
            hit_q   <= '0;
            req_q   <= '0;
          end
        end
        S_SWITCH: begin
          if (switch_ack) begin
            mode_q    <= target_q;
            score_q   <= '0;
            hit_q     <= '0;
            req_q     <= '0;
            pending_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mutative_policy_ctrl.sv
// tb/tb_mutative_policy_ctrl.sv - self-checking bench for mutative_policy_ctrl
module tb_mutative_policy_ctrl;

  localparam int NM  = 4;
  localparam int CW  = 16;
  localparam int WIN = 64;
  localparam int UP  = 32;
  localparam int DN  = 16;
  localparam int CWT = 2;
  localparam int KWT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cpu_req, cache_ready, rcv, rch, rcf, fah, faf, force_valid, switch_ack;
  logic [1:0]  force_mode, mode, target_mode;
  logic        switch_req;
  logic [15:0] hit_count, req_count, score;

  logic        s_cpu_req, s_cache_ready, s_switch_ack, s_switch_req;
  logic [1:0]  s_mode, s_target_mode;
  logic [7:0]  s_hit_count, s_req_count, s_score;

  int errors = 0;
  int checks = 0;
  int m_score, m_hit, m_req, m_mode, s_m_score;

  mutative_policy_ctrl #(
    .NUM_MODES(NM), .CNT_W(CW), .WINDOW(WIN), .UP_THRESH(UP), .DOWN_THRESH(DN),
    .CONFLICT_WT(CWT), .CAPACITY_WT(KWT)
  ) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cache_ready(cache_ready),
    .real_cache_valid(rcv), .real_cache_hit(rch), .real_cache_full(rcf),
    .full_assoc_hit(fah), .full_assoc_full(faf),
    .force_valid(force_valid), .force_mode(force_mode),
    .mode(mode), .switch_req(switch_req), .target_mode(target_mode), .switch_ack(switch_ack),
    .hit_count(hit_count), .req_count(req_count), .score(score)
  );

  mutative_policy_ctrl #(
    .NUM_MODES(NM), .CNT_W(8), .WINDOW(200), .UP_THRESH(UP), .DOWN_THRESH(DN),
    .CONFLICT_WT(CWT), .CAPACITY_WT(KWT)
  ) dut_sat (
    .clk(clk), .rst(rst), .cpu_req(s_cpu_req), .cache_ready(s_cache_ready),
    .real_cache_valid(1'b1), .real_cache_hit(1'b0), .real_cache_full(1'b1),
    .full_assoc_hit(1'b1), .full_assoc_full(1'b0),
    .force_valid(1'b0), .force_mode(2'd0),
    .mode(s_mode), .switch_req(s_switch_req), .target_mode(s_target_mode),
    .switch_ack(s_switch_ack),
    .hit_count(s_hit_count), .req_count(s_req_count), .score(s_score)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_signed(input int v, input int w);
    int mx = (1 << (w - 1)) - 1;
    int mn = -(1 << (w - 1));
    return (v > mx) ? mx : ((v < mn) ? mn : v);
  endfunction

  task automatic model_clear();
    m_score = 0;
    m_hit   = 0;
    m_req   = 0;
  endtask

  // Entered at the negedge where the DUT is in SWITCH; completes the handshake.
  task automatic do_switch(input int tgt);
    chk("switch_target", target_mode, tgt);
    repeat ($urandom_range(0, 3)) begin
      cpu_req     = 1'($urandom);
      force_valid = 1'($urandom);
      force_mode  = 2'($urandom);
      @(negedge clk);
      chk("switch_hold_req", switch_req, 1);
      chk("switch_hold_target", target_mode, tgt);
    end
    cpu_req     = 1'b0;
    force_valid = 1'b0;
    switch_ack  = 1'b1;
    @(negedge clk);
    switch_ack  = 1'b0;
    m_mode = tgt;
    model_clear();
    chk("ack_mode", mode, m_mode);
    chk("ack_switch_req_low", switch_req, 0);
    chk("ack_score_clear", score, 0);
    chk("ack_req_clear", req_count, 0);
    chk("ack_hit_clear", hit_count, 0);
  endtask

  task automatic eval_end();
    int  tgt = m_mode;
    bit  sw  = 1'b0;
    if (m_score >= UP && m_mode < NM - 1) begin
      sw = 1'b1; tgt = m_mode + 1;
    end else if (m_score <= -DN && m_mode > 0) begin
      sw = 1'b1; tgt = m_mode - 1;
    end
    @(negedge clk);
    chk("eval_switch_req", switch_req, sw);
    if (sw) begin
      do_switch(tgt);
    end else begin
      model_clear();
      chk("eval_score_clear", score, 0);
      chk("eval_req_clear", req_count, 0);
      chk("eval_hit_clear", hit_count, 0);
      chk("eval_mode_hold", mode, m_mode);
    end
  endtask

  // One CPU request with the given outcome; cache_ready arrives dly cycles after CLASSIFY.
  task automatic do_req(input bit v, input bit h, input bit rf, input bit fh, input bit ff,
                        input int dly);
    cpu_req = 1'b1; rcv = v; rch = h; rcf = rf; fah = fh; faf = ff;
    @(negedge clk);
    cpu_req = 1'b0;
    cache_ready = (dly == 0);
    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      chk("wait_no_switch", switch_req, 0);
      cache_ready = (k == dly);
    end
    @(negedge clk);
    cache_ready = 1'b0;
    if (v && !h && (fh || !rf))            m_score = sat_signed(m_score + CWT, CW);
    else if (v && !h && !fh && rf && ff)   m_score = sat_signed(m_score - KWT, CW);
    else if (v && h && m_hit < 65535)      m_hit++;
    if (m_req < 65535) m_req++;
    chk("req_score", score, m_score[15:0]);
    chk("req_hit", hit_count, m_hit);
    chk("req_count", req_count, m_req);
    if (m_req >= WIN) eval_end();
  endtask

  task automatic do_force(input int fm, input bit with_req);
    force_valid = 1'b1; force_mode = 2'(fm); cpu_req = with_req;
    @(negedge clk);
    force_valid = 1'b0; cpu_req = 1'b0;
    chk("force_switch_req", switch_req, 1);
    chk("force_not_classified", req_count, m_req);
    do_switch((fm > NM - 1) ? NM - 1 : fm);
  endtask

  initial begin
    int bias, r;
    rst = 1'b1; cpu_req = 1'b0; cache_ready = 1'b0; rcv = 1'b0; rch = 1'b0; rcf = 1'b0;
    fah = 1'b0; faf = 1'b0; force_valid = 1'b0; force_mode = 2'd0; switch_ack = 1'b0;
    s_cpu_req = 1'b0; s_cache_ready = 1'b0; s_switch_ack = 1'b0;
    m_mode = 0; s_m_score = 0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_mode", mode, 0);
    chk("rst_target", target_mode, 0);
    chk("rst_switch_req", switch_req, 0);
    chk("rst_score", score, 0);
    chk("rst_hit", hit_count, 0);
    chk("rst_req", req_count, 0);
    rst = 1'b0;

    // 64 conflict misses promote to mode 1
    for (int i = 0; i < 64; i++) do_req(1, 0, 1, 1, 0, (i == 63) ? 2 : 0);
    chk("promote_mode", mode, 1);
    // 64 capacity misses demote back to mode 0
    for (int i = 0; i < 64; i++) do_req(1, 0, 1, 0, 1, $urandom_range(0, 2));
    chk("demote_mode", mode, 0);
    // in mode 0 capacity misses cannot demote further
    for (int i = 0; i < 64; i++) do_req(1, 0, 1, 0, 1, $urandom_range(0, 1));
    chk("floor_mode", mode, 0);

    // stray ack outside SWITCH is ignored
    switch_ack = 1'b1;
    @(negedge clk);
    switch_ack = 1'b0;
    chk("stray_ack_mode", mode, 0);
    chk("stray_ack_switch_req", switch_req, 0);

    // a few unscored/hit requests, then force wins over cpu_req
    do_req(0, 0, 1, 1, 1, 0);
    do_req(1, 1, 0, 0, 0, 1);
    do_force(3, 1'b1);
    chk("force_mode3", mode, 3);

    // reset during SWITCH abandons the switch and ignores the late ack
    force_valid = 1'b1; force_mode = 2'd1;
    @(negedge clk);
    force_valid = 1'b0;
    chk("pre_rst_switch_req", switch_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_mode = 0;
    model_clear();
    chk("rst_mid_switch_req", switch_req, 0);
    chk("rst_mid_mode", mode, 0);
    switch_ack = 1'b1;
    @(negedge clk);
    switch_ack = 1'b0;
    chk("late_ack_mode", mode, 0);
    chk("late_ack_switch_req", switch_req, 0);

    // randomized windows against the reference model
    for (int w = 0; w < 7; w++) begin
      bias = $urandom_range(0, 2);
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 3);
        if ($urandom_range(0, 79) == 0) begin
          do_force($urandom_range(0, 3), 1'($urandom));
        end else if (r == 0 || bias == 0) begin
          do_req(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3));
        end else if (bias == 1) begin
          do_req(1, 0, 1'($urandom), 1, 1'($urandom), $urandom_range(0, 3));
        end else begin
          do_req(1, 0, 1, 0, 1, $urandom_range(0, 3));
        end
      end
    end

    // narrow counters: 100 conflict misses saturate an 8-bit score at 127
    for (int i = 0; i < 100; i++) begin
      s_cpu_req = 1'b1;
      @(negedge clk);
      s_cpu_req = 1'b0; s_cache_ready = 1'b1;
      @(negedge clk);
      s_cache_ready = 1'b0;
      s_m_score = sat_signed(s_m_score + CWT, 8);
      chk("sat_score", s_score, s_m_score[7:0]);
      chk("sat_req", s_req_count, i + 1);
    end
    chk("sat_final_127", s_score, 127);
    chk("sat_no_switch", s_switch_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
